// File: rtl/load_store_unit.sv
// Load/store unit: maps byte..doubleword accesses onto a 64-bit, word-write-only data memory.
// Sub-doubleword stores use read-modify-write. Loads are sign- or zero-extended.
module load_store_unit #(
  parameter int xlen = 64
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic            req_is_store,
  input  logic [2:0]      req_funct3,
  input  logic [xlen-1:0] req_addr,
  input  logic [xlen-1:0] req_wdata,
  output logic            resp_valid,
  output logic [xlen-1:0] resp_rdata,
  output logic            resp_fault,
  output logic [xlen-1:0] mem_address,
  output logic [xlen-1:0] mem_write_data,
  output logic            mem_write_en,
  output logic            mem_read_en,
  input  logic [xlen-1:0] mem_read_data
);

  // Handshake: a request is taken on a rising edge where req_valid && req_ready;
  // req_ready is high only in IDLE and not before the first edge after reset.
  typedef enum logic [1:0] {IDLE, READ, WRITE, RESP} state_t;

  state_t          state, state_next;
  logic            live;
  logic            is_store_q;
  logic [2:0]      funct3_q;
  logic [xlen-1:0] addr_q;
  logic [xlen-1:0] wdata_q;
  logic [xlen-1:0] merge_q;
  logic [xlen-1:0] result_q;
  logic            fault_q;

  logic            accept;
  logic            illegal_in;
  logic            misaligned_in;
  logic            fault_in;
  logic [5:0]      shamt;
  logic [xlen-1:0] lane;
  logic [xlen-1:0] load_ext;
  logic [xlen-1:0] mask;
  logic [xlen-1:0] merged;

  assign accept = req_valid && req_ready;

  always_comb begin
    illegal_in    = req_is_store ? req_funct3[2] : (req_funct3 == 3'b111);
    misaligned_in = 1'b0;
    case (req_funct3[1:0])
      2'b00:   misaligned_in = 1'b0;
      2'b01:   misaligned_in = req_addr[0];
      2'b10:   misaligned_in = |req_addr[1:0];
      default: misaligned_in = |req_addr[2:0];
    endcase
    fault_in = illegal_in || misaligned_in;
  end

  // Lane offset in bits, little-endian within the doubleword.
  assign shamt = {addr_q[2:0], 3'b000};
  assign lane  = mem_read_data >> shamt;

  always_comb begin
    load_ext = lane;
    case (funct3_q)
      3'b000:  load_ext = {{(xlen-8){lane[7]}}, lane[7:0]};
      3'b001:  load_ext = {{(xlen-16){lane[15]}}, lane[15:0]};
      3'b010:  load_ext = {{(xlen-32){lane[31]}}, lane[31:0]};
      3'b100:  load_ext = {{(xlen-8){1'b0}}, lane[7:0]};
      3'b101:  load_ext = {{(xlen-16){1'b0}}, lane[15:0]};
      3'b110:  load_ext = {{(xlen-32){1'b0}}, lane[31:0]};
      default: load_ext = lane;
    endcase
  end

  always_comb begin
    case (funct3_q[1:0])
      2'b00:   mask = {{(xlen-8){1'b0}}, 8'hFF};
      2'b01:   mask = {{(xlen-16){1'b0}}, 16'hFFFF};
      2'b10:   mask = {{(xlen-32){1'b0}}, 32'hFFFF_FFFF};
      default: mask = '1;
    endcase
    merged = (merge_q & ~(mask << shamt)) | ((wdata_q & mask) << shamt);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      live  <= 1'b0;
    end else begin
      state <= state_next;
      live  <= 1'b1;
    end
  end

  always_comb begin
    state_next     = state;
    req_ready      = 1'b0;
    resp_valid     = 1'b0;
    resp_fault     = 1'b0;
    resp_rdata     = '0;
    mem_address    = '0;
    mem_write_data = '0;
    mem_write_en   = 1'b0;
    mem_read_en    = 1'b0;
    case (state)
      IDLE: begin
        req_ready = live;
        if (accept) begin
          if (fault_in)
            state_next = RESP;
          else if (req_is_store && req_funct3 == 3'b011)
            state_next = WRITE;
          else
            state_next = READ;
        end
      end
      READ: begin
        mem_read_en = 1'b1;
        mem_address = {addr_q[xlen-1:3], 3'b000};
        state_next  = is_store_q ? WRITE : RESP;
      end
      WRITE: begin
        mem_write_en   = 1'b1;
        mem_address    = {addr_q[xlen-1:3], 3'b000};
        mem_write_data = (funct3_q == 3'b011) ? wdata_q : merged;
        state_next     = RESP;
      end
      default: begin
        resp_valid = 1'b1;
        resp_fault = fault_q;
        resp_rdata = result_q;
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      is_store_q <= 1'b0;
      funct3_q   <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      merge_q    <= '0;
      result_q   <= '0;
      fault_q    <= 1'b0;
    end else begin
      if (accept) begin
        is_store_q <= req_is_store;
        funct3_q   <= req_funct3;
        addr_q     <= req_addr;
        wdata_q    <= req_wdata;
        fault_q    <= fault_in;
        result_q   <= '0;
      end
      if (state == READ) begin
        if (is_store_q)
          merge_q <= mem_read_data;
        else
          result_q <= load_ext;
      end
    end
  end

endmodule
